// File: rtl/mul3_stream_sched_if.sv
// Requester and detector signal bundle for the shared divisible-by-3 scheduler.
interface mul3_stream_sched_if #(
  parameter int unsigned W = 10
);
  logic         req0;
  logic         req1;
  logic [W-1:0] word0;
  logic [W-1:0] word1;
  logic         gnt0;
  logic         gnt1;
  logic         det_I;
  logic         det_res;
  logic         det_out;
  logic         busy;
  logic         done;
  logic         done_id;
  logic         result;
  logic [W-1:0] trace;

  // master: requesters plus the detector; slave: the scheduler
  modport master (
    output req0, req1, word0, word1, det_out,
    input  gnt0, gnt1, det_I, det_res, busy, done, done_id, result, trace
  );

  modport slave (
    input  req0, req1, word0, word1, det_out,
    output gnt0, gnt1, det_I, det_res, busy, done, done_id, result, trace
  );
endinterface

// File: rtl/mul3_stream_sched.sv
// Round-robin scheduler that feeds W-bit jobs MSB-first into one shared serial
// divisible-by-3 detector and returns the per-prefix trace and final result.
module mul3_stream_sched #(
  parameter int unsigned W = 10
) (
  input  logic                clk,
  input  logic                res,
  mul3_stream_sched_if.slave  bus
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [W-1:0]  word_q, word_q_nxt;
  logic          owner, owner_nxt;
  logic          last, last_nxt;
  logic [W-1:1]  trace_w, trace_w_nxt;

  logic          det_i_q, det_i_nxt;
  logic          det_res_q, det_res_nxt;
  logic          busy_q, busy_nxt;
  logic          done_q, done_nxt;
  logic          done_id_q, done_id_nxt;
  logic          result_q, result_nxt;
  logic [W-1:0]  trace_q, trace_nxt;
  logic          gnt0_c, gnt1_c;

  // State and registered outputs
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= S_IDLE;
      cnt       <= '0;
      word_q    <= '0;
      owner     <= 1'b0;
      last      <= 1'b1;
      trace_w   <= '0;
      det_i_q   <= 1'b0;
      det_res_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      result_q  <= 1'b0;
      trace_q   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      word_q    <= word_q_nxt;
      owner     <= owner_nxt;
      last      <= last_nxt;
      trace_w   <= trace_w_nxt;
      det_i_q   <= det_i_nxt;
      det_res_q <= det_res_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      done_id_q <= done_id_nxt;
      result_q  <= result_nxt;
      trace_q   <= trace_nxt;
    end
  end

  // Next-state, arbitration and capture logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    word_q_nxt  = word_q;
    owner_nxt   = owner;
    last_nxt    = last;
    trace_w_nxt = trace_w;
    det_i_nxt   = 1'b0;
    det_res_nxt = 1'b1;
    busy_nxt    = 1'b1;
    done_nxt    = 1'b0;
    done_id_nxt = done_id_q;
    result_nxt  = result_q;
    trace_nxt   = trace_q;
    gnt0_c      = 1'b0;
    gnt1_c      = 1'b0;

    case (state)
      S_IDLE: begin
        // last==1 means requester 1 was served last, so requester 0 wins a tie
        if (res && bus.req0 && (!bus.req1 || last)) begin
          gnt0_c     = 1'b1;
          word_q_nxt = bus.word0;
          owner_nxt  = 1'b0;
          state_nxt  = S_CLEAR;
        end else if (res && bus.req1) begin
          gnt1_c     = 1'b1;
          word_q_nxt = bus.word1;
          owner_nxt  = 1'b1;
          state_nxt  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_nxt   = CW'(W - 1);
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        // detector output lags the consumed bit by one cycle
        if (cnt != CW'(W - 1)) begin
          trace_w_nxt[cnt + 1'b1] = bus.det_out;
        end
        if (cnt == '0) begin
          state_nxt = S_DRAIN;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_DRAIN: begin
        result_nxt  = bus.det_out;
        trace_nxt   = {trace_w, bus.det_out};
        done_nxt    = 1'b1;
        done_id_nxt = owner;
        state_nxt   = S_DONE;
      end
      S_DONE: begin
        last_nxt  = owner;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Detector drive is registered, so it follows the state being entered
    case (state_nxt)
      S_IDLE:  busy_nxt = 1'b0;
      S_SHIFT: begin
        det_res_nxt = 1'b0;
        det_i_nxt   = word_q_nxt[cnt_nxt];
      end
      S_DRAIN: det_res_nxt = 1'b0;
      default: ;
    endcase
  end

  assign bus.gnt0    = gnt0_c;
  assign bus.gnt1    = gnt1_c;
  assign bus.det_I   = det_i_q;
  assign bus.det_res = det_res_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.result  = result_q;
  assign bus.trace   = trace_q;

endmodule

// File: tb/tb_mul3_stream_sched.sv
// Directed bench for mul3_stream_sched with a behavioural divisible-by-3 detector.
module tb_mul3_stream_sched;

  localparam int unsigned W = 10;

  logic clk = 1'b0;
  logic res = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  mul3_stream_sched_if #(.W(W)) bus ();

  mul3_stream_sched #(.W(W)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Serial detector: state=(2*state+bit) mod 3, out valid the cycle after
  logic [1:0] det_st = 2'd0;
  always @(posedge clk) begin
    if (bus.det_res) det_st <= 2'd0;
    else             det_st <= 2'((2 * det_st + bus.det_I) % 3);
  end
  assign bus.det_out = (det_st == 2'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // One job from a lone requester; cycle 0 is the grant cycle
  task automatic run_job(input bit id, input logic [W-1:0] w, input logic exp_res,
                         input logic [W-1:0] exp_tr, input bit chk_det);
    @(posedge clk); #1;
    if (id) begin bus.req1 = 1'b1; bus.word1 = w; end
    else    begin bus.req0 = 1'b1; bus.word0 = w; end
    @(negedge clk);
    check("gnt_own",   id ? bus.gnt1 : bus.gnt0, 1);
    check("gnt_other", id ? bus.gnt0 : bus.gnt1, 0);
    check("busy_idle", bus.busy, 0);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (chk_det) begin
        if (k == 1) check("det_res_clear", bus.det_res, 1);
        if (k >= 2 && k <= 11) begin
          check("det_I_seq", bus.det_I, w[11 - k]);
          check("det_res_shift", bus.det_res, 0);
        end
        if (k == 12) check("det_res_drain", bus.det_res, 0);
      end
      if (k == 1) check("busy_clear", bus.busy, 1);
      if (k < 13) check("done_early", bus.done, 0);
    end
    check("done",    bus.done, 1);
    check("busy_done", bus.busy, 1);
    check("done_id", bus.done_id, id);
    check("result",  bus.result, exp_res);
    check("trace",   bus.trace, exp_tr);
  endtask

  int g0, g1, nd, ndone;
  logic [W-1:0] d_tr  [2];
  logic         d_id  [2];
  logic         d_res [2];

  initial begin
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    bus.word0 = 10'b1010110010;
    bus.word1 = 10'b0100101010;
    #23;
    check("rst_gnt0",    bus.gnt0, 0);
    check("rst_gnt1",    bus.gnt1, 0);
    check("rst_det_I",   bus.det_I, 0);
    check("rst_det_res", bus.det_res, 1);
    check("rst_busy",    bus.busy, 0);
    check("rst_done",    bus.done, 0);
    check("rst_trace",   bus.trace, 0);
    check("rst_result",  bus.result, 0);

    // Both requesters held from reset: 0 first, then 1 fourteen cycles later
    @(posedge clk); #1;
    res = 1'b1;
    g0 = -1; g1 = -1; nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.gnt0 && g0 < 0) g0 = c;
      if (bus.gnt1 && g1 < 0) g1 = c;
      if (bus.done && nd < 2) begin
        d_id[nd] = bus.done_id; d_res[nd] = bus.result; d_tr[nd] = bus.trace; nd++;
      end
      @(posedge clk); #1;
      if (g0 >= 0) bus.req0 = 1'b0;
      if (g1 >= 0) bus.req1 = 1'b0;
    end
    check("rr_g0_cycle", g0, 0);
    check("rr_g1_cycle", g1, 14);
    check("rr_ndone",    nd, 2);
    check("rr_id0",      d_id[0], 0);
    check("rr_res0",     d_res[0], 1);
    check("rr_id1",      d_id[1], 1);
    check("rr_res1",     d_res[1], 0);
    check("rr_trace1",   d_tr[1], 10'b1000110000);

    run_job(1'b0, 10'd690,  1'b1, 10'b0000100011, 1'b1);
    run_job(1'b1, 10'd685,  1'b0, 10'b0000110110, 1'b0);
    run_job(1'b0, 10'd0,    1'b1, 10'h3FF,        1'b0);
    run_job(1'b0, 10'h3FF,  1'b1, 10'h155,        1'b0);

    // Reset in cycle 6 of a job abandons it
    @(posedge clk); #1;
    bus.req0 = 1'b1; bus.word0 = 10'd690;
    @(negedge clk);
    check("mid_gnt0", bus.gnt0, 1);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_det_I_pre", bus.det_I, 1);
    res = 1'b0;
    #1;
    check("mid_det_I",   bus.det_I, 0);
    check("mid_det_res", bus.det_res, 1);
    check("mid_busy",    bus.busy, 0);
    check("mid_result",  bus.result, 0);
    check("mid_trace",   bus.trace, 0);
    repeat (2) @(posedge clk);
    #1;
    res = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("mid_no_done", ndone, 0);
    run_job(1'b0, 10'd690, 1'b1, 10'b0000100011, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul3_stream_sched.md
# mul3_stream_sched

Controller that shares one serial divisible-by-3 detector between two requesters. It grants one 10-bit job at a time with round-robin arbitration and clears the detector before each job. It then shifts the word into the detector MSB-first, captures the detector output after every bit, and returns the per-prefix trace plus the final result. It sits between the requesting blocks and the `Multiple_of_3` detector, and it drives all of the detector's inputs.

## Interface
Parameters:
- `W`, default 10: word width, which is also the number of shift cycles per job.

Ports:
- `clk`, input, 1: single clock; everything is rising-edge.
- `res`, input, 1: asynchronous, active-low reset.
- `req0` / `req1`, input, 1 each: job request; held high until the matching grant.
- `word0` / `word1`, input, W each: job data; must be stable while the matching `req` is high.
- `gnt0` / `gnt1`, output, 1 each: one-cycle pulse; the word is latched on this edge.
- `det_I`, output, 1: serial bit to the detector.
- `det_res`, output, 1: detector reset, active-high (the detector's own convention).
- `det_out`, input, 1: detector output.
- `busy`, output, 1: high from grant until `done`, inclusive.
- `done`, output, 1: one-cycle pulse when `result` and `trace` are valid.
- `done_id`, output, 1: requester that owns the finished job (0 or 1).
- `result`, output, 1: 1 when the latched word mod 3 == 0 (equals `trace[0]`).
- `trace`, output, W: `trace[j]` = `det_out` captured after bit j was consumed.

## Operation
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE:
  - `det_res`=1, `busy`=0.
  - If any req is high: pulse the chosen gnt, latch its word and id, go to CLEAR.
- Arbitration:
  - Round-robin with a last-granted pointer; the pointer resets to "1 was last", so req0 wins the first tie.
  - A single requester is always granted.
  - Grants are issued only in IDLE; requests raised while busy wait.
- CLEAR (1 cycle): `det_res`=1, `det_I`=0. Bit counter loads W-1.
- SHIFT (W cycles):
  - `det_res`=0; `det_I` = latched word[cnt], starting at cnt = W-1 and counting down to 0.
  - From the second SHIFT cycle on, capture `det_out` into `trace[cnt+1]`.
  - After cnt = 0, go to DRAIN.
- DRAIN (1 cycle): `det_res`=0, `det_I`=0. Capture `det_out` into `trace[0]` and `result`.
- DONE (1 cycle):
  - `done`=1; `done_id` = owner; `busy`=1; `det_res`=1.
  - Update the arbitration pointer, then go to IDLE.
- `result`, `trace` and `done_id` hold their values until the next DONE overwrites them.
- Detector model assumed by the bench: state = (2·state + bit) mod 3, updated on the edge that consumes the bit; out = (state==0), readable in the following cycle.

## Timing
- Reset values, applied asynchronously while `res`=0:
  - state=IDLE; `gnt0`=`gnt1`=0, `det_I`=0, `det_res`=1, `busy`=0, `done`=0, `done_id`=0, `result`=0, `trace`=0.
  - Pointer set so that req0 has priority.
- Reset mid-job: the job is abandoned, no `done` is produced, and the detector is held cleared via `det_res`=1.
- Latency, with the grant edge as cycle 0:
  - CLEAR is cycle 1.
  - SHIFT is cycles 2..W+1.
  - DRAIN is cycle W+2.
  - `done` is high in cycle W+3.
  - For W=10: grant to `done` takes 13 cycles.
- The earliest next grant is cycle W+4, so `done` and a grant never coincide.
- Back-to-back jobs run every W+4 cycles.
- If both reqs are held continuously, grants alternate 0,1,0,1…
- If a req drops before its grant, no job is started and no error is flagged.
- `det_I` and `det_res` are registered outputs, with no combinational path from inputs.

## Test plan
- Reset, then req0 alone with word0=10'b1010110010 (690) -> `gnt0` pulses at cycle 0; `done` at cycle 13 with `done_id`=0, `result`=1, `trace`=10'b0000100011.
- req1 alone with word1=10'b1010101101 (685) -> `done_id`=1, `result`=0, `trace`=10'b0000110110.
- req0 and req1 both held from reset (word0=690, word1=10'b0100101010 (298)):
  - First grant goes to 0, second to 1, with grants 14 cycles apart.
  - Results: 690 gives 1; 298 gives 0 with `trace`[0]=0.
- Check the `det_I` bit sequence for 690 during SHIFT: 1,0,1,0,1,1,0,0,1,0. `det_res` must be 1 in CLEAR and 0 throughout SHIFT and DRAIN.
- Assert `res`=0 in cycle 6 of a job -> outputs go to reset values immediately; no `done`; the next req0 job completes normally.
- word0=0 -> `result`=1, `trace`=all ones. word0=10'h3FF (1023) -> `result`=1.
